// File: rtl/bkm_slot_bus_engine.sv
// BKM-class option-slot bus engine: oversampled 8-bit slot bus front end,
// command FSM (ID / VIDEO / PREP / SERIAL / init space / IRQ phase),
// interrupt controller with mask, write-1-to-release and format-change source.
module bkm_slot_bus_engine #(
  parameter logic [7:0]  ID_VALUE    = 8'h88,
  parameter int          NUM_IRQ     = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          VF_WIDTH    = 3,
  parameter logic [55:0] SERIAL      = 56'h32303030353535,
  parameter int          ID_REPEAT   = 6
) (
  input  logic                clk_50mhz_in,
  input  logic                reset,
  input  logic                bus_clk,
  input  logic                ax_d,
  input  logic                r_wx,
  input  logic                slot_sel_x,
  input  logic [7:0]          data_in_x,
  output logic [7:0]          data_out,
  output logic                data_oe_x,
  output logic                int_x,
  input  logic [NUM_IRQ-1:0]  irq_req,
  input  logic [VF_WIDTH-1:0] video_format,
  output logic                rgb_comp_x,
  output logic                int_ext_x,
  output logic                video_oe_x,
  output logic                hd_sd_x
);

  localparam int CNT_W = $clog2(ID_REPEAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ID_REPEAT);

  typedef enum logic [3:0] {
    ST_IDLE, ST_GETCMD, ST_ID, ST_VIDEO, ST_PREP, ST_SERIAL,
    ST_INIT_REG, ST_INIT_DATA, ST_IRQ_PH, ST_WAIT
  } state_t;

  // Serial string byte n (byte 0 is the MSB); out-of-range indices map to byte 0.
  function automatic logic [7:0] serial_byte(input logic [2:0] idx);
    int n;
    n = (idx > 3'd6) ? 0 : int'(idx);
    return SERIAL[55 - 8*n -: 8];
  endfunction

  // Synchroniser pipeline: {bus_clk, ax_d, r_wx, true-polarity data}
  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic                         bclk_prev_q, bclk_prev_d;
  logic [10:0]                  tap_s;
  logic                         bclk_s, ax_s, rw_s, edge_s;
  logic [7:0]                   byte_s;

  state_t               state_q, state_d;
  logic                 drive_q, drive_d;
  logic [7:0]           dout_q, dout_d;
  logic [3:0]           slot_q, slot_d;
  logic [7:0]           reg_sel_q, reg_sel_d;
  logic                 irq_drive_q, irq_drive_d;
  logic [7:0]           status_q, status_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           r42_q, r42_d;
  logic [7:0]           r43_q, r43_d;
  logic                 rgb_q, rgb_d;
  logic                 int_ext_q, int_ext_d;
  logic                 video_oe_q, video_oe_d;
  logic [VF_WIDTH-1:0]  fmt_latched_q, fmt_latched_d;
  logic [CNT_W-1:0]     ser_cnt_q, ser_cnt_d;
  logic                 id_read_q, id_read_d;
  logic                 int_x_q, int_x_d;
  logic [7:0]           wr_rel_s;
  logic [7:0]           ev_s;
  logic                 fmt_ev_s;

  assign tap_s  = sync_q[SYNC_STAGES-1];
  assign bclk_s = tap_s[10];
  assign ax_s   = tap_s[9];
  assign rw_s   = tap_s[8];
  assign byte_s = tap_s[7:0];
  assign edge_s = bclk_s & ~bclk_prev_q;

  // Shift raw pins into the synchroniser and remember the last synced strobe.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {bus_clk, ax_d, r_wx, ~data_in_x}};
    bclk_prev_d = bclk_s;
  end

  // Bus FSM next state plus interrupt controller next state.
  always_comb begin
    state_d       = state_q;
    drive_d       = drive_q;
    dout_d        = dout_q;
    slot_d        = slot_q;
    reg_sel_d     = reg_sel_q;
    irq_drive_d   = irq_drive_q;
    mask_d        = mask_q;
    r42_d         = r42_q;
    r43_d         = r43_q;
    rgb_d         = rgb_q;
    int_ext_d     = int_ext_q;
    video_oe_d    = video_oe_q;
    ser_cnt_d     = ser_cnt_q;
    id_read_d     = id_read_q;
    wr_rel_s      = 8'h00;

    if (edge_s) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_s == 8'hFF && !ax_s && rw_s) begin
            state_d = ST_GETCMD;
          end else if (byte_s == 8'h10 && !ax_s && !rw_s) begin
            if (!slot_sel_x) begin
              state_d = ST_INIT_REG;
              drive_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (byte_s == 8'h02 && !ax_s && !rw_s) begin
            state_d = ST_IRQ_PH;
            drive_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GETCMD: begin
          if (byte_s[7:4] == slot_q) begin
            drive_d = 1'b1;
            dout_d  = byte_s;
            case (byte_s[3:0])
              4'd0:    begin state_d = ST_ID; dout_d = dout_q; end
              4'd1:    state_d = ST_VIDEO;
              4'd2:    state_d = ST_PREP;
              4'd3:    state_d = ST_SERIAL;
              default: begin state_d = ST_WAIT; drive_d = 1'b0; dout_d = dout_q; end
            endcase
          end else begin
            state_d = ST_WAIT;
            drive_d = 1'b0;
          end
        end
        ST_ID: begin
          dout_d    = ID_VALUE;
          id_read_d = 1'b1;
          state_d   = ST_WAIT;
        end
        ST_VIDEO: begin
          if (!ax_s) begin
            reg_sel_d = byte_s;
            dout_d    = (byte_s == 8'h31) ? 8'(fmt_latched_q) : byte_s;
          end else begin
            if (!rw_s) begin
              case (reg_sel_q)
                8'h00: rgb_d = (byte_s != 8'h04);
                8'h10: begin
                  int_ext_d  = byte_s[0];
                  video_oe_d = ~byte_s[3];
                end
                default: rgb_d = rgb_q;
              endcase
            end else begin
              rgb_d = rgb_q;
            end
            state_d = ST_WAIT;
          end
        end
        ST_PREP: begin
          if (!ax_s) begin
            dout_d = byte_s;
          end else begin
            dout_d  = rw_s ? dout_q : byte_s;
            state_d = ST_WAIT;
          end
        end
        ST_SERIAL: begin
          if (!ax_s) begin
            if (byte_s == 8'h00) begin
              if (ser_cnt_q < CNT_MAX) begin
                dout_d    = ID_VALUE;
                ser_cnt_d = ser_cnt_q + CNT_W'(1);
              end else begin
                dout_d = serial_byte(3'd0);
              end
            end else if (byte_s <= 8'd6) begin
              dout_d = serial_byte(byte_s[2:0]);
            end else begin
              dout_d = serial_byte(3'd0);
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_INIT_REG: begin
          reg_sel_d = byte_s;
          case (byte_s)
            8'h40:   dout_d = mask_q;
            8'h41:   dout_d = status_q;
            8'h42:   dout_d = r42_q;
            8'h43:   dout_d = r43_q;
            default: dout_d = 8'hFF;
          endcase
          state_d = ST_INIT_DATA;
        end
        ST_INIT_DATA: begin
          if (!rw_s && !slot_sel_x) begin
            case (reg_sel_q)
              8'h03:   slot_d   = byte_s[3:0];
              8'h40:   mask_d   = byte_s;
              8'h41:   wr_rel_s = byte_s;
              8'h42:   r42_d    = byte_s;
              8'h43:   r43_d    = byte_s;
              default: slot_d   = slot_q;
            endcase
          end else begin
            slot_d = slot_q;
          end
          dout_d  = 8'hFF;
          state_d = ST_WAIT;
        end
        ST_IRQ_PH: begin
          case (byte_s)
            8'h01: begin irq_drive_d = 1'b1; dout_d = status_q; end
            8'h00: begin irq_drive_d = 1'b0; dout_d = 8'hFF; end
            default: begin
              drive_d     = 1'b0;
              irq_drive_d = 1'b0;
              dout_d      = 8'hFF;
              state_d     = ST_IDLE;
            end
          endcase
        end
        ST_WAIT: begin
          if (byte_s == 8'hFF && !ax_s && rw_s) begin
            state_d = ST_IDLE;
            drive_d = 1'b0;
            dout_d  = 8'hFF;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Format change only after the card has been identified and all is quiet.
    fmt_ev_s      = id_read_q && (video_format != fmt_latched_q) && (status_q == 8'hFF);
    fmt_latched_d = fmt_ev_s ? video_format : fmt_latched_q;
    ev_s          = 8'(irq_req);
    ev_s[7]       = fmt_ev_s;
    // Release first, then events so a coincident event keeps the bit pending.
    status_d      = (status_q | wr_rel_s) & ~ev_s;
    int_x_d       = ~|(~status_q & mask_q);
  end

  // All state flops with synchronous active-high reset.
  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      sync_q        <= '0;
      bclk_prev_q   <= 1'b0;
      state_q       <= ST_IDLE;
      drive_q       <= 1'b0;
      dout_q        <= 8'hFF;
      slot_q        <= 4'h0;
      reg_sel_q     <= 8'h00;
      irq_drive_q   <= 1'b0;
      status_q      <= 8'hFF;
      mask_q        <= 8'hFF;
      r42_q         <= 8'hFD;
      r43_q         <= 8'hFD;
      rgb_q         <= 1'b0;
      int_ext_q     <= 1'b0;
      video_oe_q    <= 1'b0;
      fmt_latched_q <= '0;
      ser_cnt_q     <= '0;
      id_read_q     <= 1'b0;
      int_x_q       <= 1'b1;
    end else begin
      sync_q        <= sync_d;
      bclk_prev_q   <= bclk_prev_d;
      state_q       <= state_d;
      drive_q       <= drive_d;
      dout_q        <= dout_d;
      slot_q        <= slot_d;
      reg_sel_q     <= reg_sel_d;
      irq_drive_q   <= irq_drive_d;
      status_q      <= status_d;
      mask_q        <= mask_d;
      r42_q         <= r42_d;
      r43_q         <= r43_d;
      rgb_q         <= rgb_d;
      int_ext_q     <= int_ext_d;
      video_oe_q    <= video_oe_d;
      fmt_latched_q <= fmt_latched_d;
      ser_cnt_q     <= ser_cnt_d;
      id_read_q     <= id_read_d;
      int_x_q       <= int_x_d;
    end
  end

  // Driver enable follows the raw pins so the bus is released immediately.
  assign data_oe_x  = ~(drive_q & r_wx & ax_d & ~reset);
  assign data_out   = dout_q;
  assign int_x      = int_x_q;
  assign rgb_comp_x = rgb_q;
  assign int_ext_x  = int_ext_q;
  assign video_oe_x = video_oe_q;
  assign hd_sd_x    = ~((fmt_latched_q == VF_WIDTH'(1)) | (fmt_latched_q == VF_WIDTH'(2)));

endmodule

// File: tb/tb_bkm_slot_bus_engine.sv
// Directed bench for bkm_slot_bus_engine: bus transfers with a queue of
// expected read bytes, plus interrupt, video-control and reset checks.
module tb_bkm_slot_bus_engine;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_clk, ax_d, r_wx, slot_sel_x;
  logic [7:0] data_in_x;
  logic [7:0] data_out;
  logic       data_oe_x, int_x;
  logic [3:0] irq_req;
  logic [2:0] video_format;
  logic       rgb_comp_x, int_ext_x, video_oe_x, hd_sd_x;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  bkm_slot_bus_engine #(
    .ID_VALUE(8'h88), .NUM_IRQ(4), .SYNC_STAGES(SYNC), .VF_WIDTH(3),
    .SERIAL(56'h32303030353535), .ID_REPEAT(6)
  ) dut (
    .clk_50mhz_in(clk), .reset(reset), .bus_clk(bus_clk), .ax_d(ax_d),
    .r_wx(r_wx), .slot_sel_x(slot_sel_x), .data_in_x(data_in_x),
    .data_out(data_out), .data_oe_x(data_oe_x), .int_x(int_x),
    .irq_req(irq_req), .video_format(video_format), .rgb_comp_x(rgb_comp_x),
    .int_ext_x(int_ext_x), .video_oe_x(video_oe_x), .hd_sd_x(hd_sd_x)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_pins(input logic [7:0] b, input logic ax, input logic rw, input logic sel);
    data_in_x  = ~b;
    ax_d       = ax;
    r_wx       = rw;
    slot_sel_x = sel;
  endtask

  // One bus byte; optional irq pulse in the edge cycle; optional data_out check.
  task automatic xfer_core(input logic [7:0] b, input logic ax, input logic rw,
                           input logic sel, input logic [3:0] irqv,
                           input logic chk, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    if (chk) exp_q.push_back(exp);
    set_pins(b, ax, rw, sel);
    tick(2);
    bus_clk = 1'b1;
    tick(SYNC);
    irq_req = irqv;
    tick(1);
    irq_req = 4'h0;
    tick(1);
    if (chk) begin
      e = exp_q.pop_front();
      check(tag, data_out, e);
    end
    bus_clk = 1'b0;
    tick(SYNC + 2);
  endtask

  task automatic xfer(input logic [7:0] b, input logic ax, input logic rw, input logic sel);
    xfer_core(b, ax, rw, sel, 4'h0, 1'b0, 8'h00, "");
  endtask

  task automatic xfer_chk(input logic [7:0] b, input logic ax, input logic rw,
                          input logic sel, input logic [7:0] exp, input string tag);
    xfer_core(b, ax, rw, sel, 4'h0, 1'b1, exp, tag);
  endtask

  task automatic read_reg(input logic [7:0] r, input logic [7:0] exp, input string tag);
    xfer(8'h10, 1'b0, 1'b0, 1'b0);
    xfer_chk(r, 1'b0, 1'b0, 1'b0, exp, tag);
    xfer(8'h00, 1'b1, 1'b1, 1'b0);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic write_reg(input logic [7:0] r, input logic [7:0] v);
    xfer(8'h10, 1'b0, 1'b0, 1'b0);
    xfer(r, 1'b0, 1'b0, 1'b0);
    xfer(v, 1'b1, 1'b0, 1'b0);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vid_write(input logic [7:0] r, input logic [7:0] v);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h21, 1'b0, 1'b0, 1'b1);
    xfer(r, 1'b0, 1'b0, 1'b1);
    xfer(v, 1'b1, 1'b0, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_req = v;
    tick(1);
    irq_req = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    bus_clk = 1'b0;
    irq_req = 4'h0;
    video_format = 3'd0;
    set_pins(8'h00, 1'b0, 1'b1, 1'b1);
    tick(5);
    check("rst_dout", data_out, 8'hFF);
    check("rst_oe", data_oe_x, 1'b1);
    check("rst_int", int_x, 1'b1);
    check("rst_rgb", rgb_comp_x, 1'b0);
    check("rst_vidoe", video_oe_x, 1'b0);
    check("rst_hdsd", hd_sd_x, 1'b1);
    reset = 1'b0;
    tick(2);

    // ID read at slot 0 with latency measurement
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h00, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h88);
    set_pins(8'h00, 1'b1, 1'b1, 1'b1);
    tick(2);
    check("id_oe_low", data_oe_x, 1'b0);
    bus_clk = 1'b1;
    tick(SYNC);
    check("id_lat_early", data_out, 8'hFF);
    tick(1);
    check("id_lat", data_out, exp_q.pop_front());
    tick(1);
    bus_clk = 1'b0;
    tick(SYNC + 2);
    set_pins(8'hFF, 1'b0, 1'b1, 1'b1);
    #1;
    check("id_oe_cmd_high", data_oe_x, 1'b1);
    xfer_chk(8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, "wait_to_idle");

    // move to slot 2; slot 2 answers, slot 0 is foreign
    write_reg(8'h03, 8'h02);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h20, 1'b0, 1'b0, 1'b1);
    xfer_chk(8'h00, 1'b1, 1'b1, 1'b1, 8'h88, "slot2_id");
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h00, 1'b0, 1'b0, 1'b1);
    set_pins(8'h00, 1'b1, 1'b1, 1'b1);
    tick(2);
    check("foreign_nodrive", data_oe_x, 1'b1);
    xfer(8'h00, 1'b1, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);

    // interrupt pend / release
    pulse(4'h2);
    check("int_delay", int_x, 1'b1);
    tick(1);
    check("int_low", int_x, 1'b0);
    read_reg(8'h41, 8'hFD, "status_fd");
    write_reg(8'h41, 8'h02);
    check("int_released", int_x, 1'b1);
    read_reg(8'h41, 8'hFF, "status_ff");
    xfer(8'h10, 1'b0, 1'b0, 1'b0);
    xfer(8'h41, 1'b0, 1'b0, 1'b0);
    xfer_core(8'h02, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 8'h00, "");
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    read_reg(8'h41, 8'hFD, "event_wins");
    write_reg(8'h41, 8'h02);

    // masked source
    write_reg(8'h40, 8'hFD);
    pulse(4'h2);
    tick(2);
    check("masked_int", int_x, 1'b1);
    read_reg(8'h41, 8'hFD, "masked_status");
    write_reg(8'h41, 8'h02);
    write_reg(8'h40, 8'hFF);
    read_reg(8'h40, 8'hFF, "mask_ff");
    read_reg(8'h42, 8'hFD, "reg42_rst");

    // format change
    video_format = 3'd4;
    tick(3);
    check("fmt_int", int_x, 1'b0);
    read_reg(8'h41, 8'h7F, "fmt_status");
    check("hdsd_hd", hd_sd_x, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer_chk(8'h21, 1'b0, 1'b0, 1'b1, 8'h21, "video_echo");
    xfer_chk(8'h31, 1'b0, 1'b0, 1'b1, 8'h04, "video_r31");
    xfer(8'h00, 1'b1, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    video_format = 3'd2;
    tick(3);
    check("hdsd_held", hd_sd_x, 1'b1);
    write_reg(8'h41, 8'h80);
    check("hdsd_sd", hd_sd_x, 1'b0);
    read_reg(8'h41, 8'h7F, "fmt2_status");
    write_reg(8'h41, 8'h80);
    check("fmt_int_clr", int_x, 1'b1);

    // serial string
    for (int i = 0; i < 7; i++) begin
      xfer(8'hFF, 1'b0, 1'b1, 1'b1);
      xfer(8'h23, 1'b0, 1'b0, 1'b1);
      xfer_chk(8'h00, 1'b0, 1'b0, 1'b1, (i < 6) ? 8'h88 : 8'h32, "serial0");
      xfer(8'h00, 1'b1, 1'b1, 1'b1);
      xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    end
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h23, 1'b0, 1'b0, 1'b1);
    xfer_chk(8'h06, 1'b0, 1'b0, 1'b1, 8'h35, "serial6");
    xfer(8'h00, 1'b1, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h23, 1'b0, 1'b0, 1'b1);
    xfer_chk(8'h09, 1'b0, 1'b0, 1'b1, 8'h32, "serial9");
    xfer(8'h00, 1'b1, 1'b1, 1'b1);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);

    // video controls
    vid_write(8'h00, 8'h05);
    check("rgb_on", rgb_comp_x, 1'b1);
    vid_write(8'h00, 8'h04);
    check("rgb_off", rgb_comp_x, 1'b0);
    vid_write(8'h10, 8'h01);
    check("intext_1", int_ext_x, 1'b1);
    check("vidoe_1", video_oe_x, 1'b1);
    vid_write(8'h10, 8'h08);
    check("intext_0", int_ext_x, 1'b0);
    check("vidoe_0", video_oe_x, 1'b0);

    // reset in the middle of a read
    pulse(4'h1);
    tick(2);
    check("pend_before_rst", int_x, 1'b0);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h20, 1'b0, 1'b0, 1'b1);
    set_pins(8'h00, 1'b1, 1'b1, 1'b1);
    tick(2);
    check("mid_oe_low", data_oe_x, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_oe_same", data_oe_x, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("post_rst_oe", data_oe_x, 1'b1);
    check("post_rst_int", int_x, 1'b1);
    check("post_rst_dout", data_out, 8'hFF);
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    xfer(8'h00, 1'b0, 1'b0, 1'b1);
    xfer_chk(8'h00, 1'b1, 1'b1, 1'b1, 8'h88, "post_rst_slot0");
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
